// File: rtl/prog_mem_loader_if.sv
// Word-stream handshake into the loader and the program-memory write port out of it.
interface prog_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Streams instruction words into program memory at consecutive PCs from a base,
// holding the core in reset until a complete, in-range load has finished.
module prog_mem_loader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int CNT_W     = 16,
    parameter int BYTE_ADDR = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     num_words,
    prog_mem_loader_if.slave     bus,
    output logic                 core_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [DATA_W-1:0]    checksum,
    output logic [CNT_W-1:0]     words_loaded
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam int              SHIFT      = (BYTE_ADDR != 0) ? $clog2(DATA_W / 8) : 0;
    localparam logic [ADDR_W-1:0] STEP     = (BYTE_ADDR != 0) ? ADDR_W'(DATA_W / 8) : ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << SHIFT;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  num_r;
    logic [ADDR_W-1:0] idx_s;
    logic              xfer_s;
    logic              in_range_s;
    logic              last_s;
    logic              launch_s;

    // in_ready is simply the registered LOAD flag, so it drops the cycle after the last word
    assign bus.in_ready = busy;
    assign xfer_s       = bus.in_valid && busy;
    assign idx_s        = addr_r >> SHIFT;
    assign in_range_s   = ({1'b0, idx_s} < DEPTH_X);
    assign last_s       = ((words_loaded + CNT_W'(1)) == num_r);
    assign launch_s     = start && (state_r != S_LOAD);

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_LOAD: begin
                if (xfer_s && !in_range_s) begin
                    state_nxt_s = S_ERR;
                end else if (xfer_s && last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_IDLE, S_DONE, S_ERR: begin
                if (start && (num_words == {CNT_W{1'b0}})) begin
                    state_nxt_s = S_DONE;
                end else if (start) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register and status flags, registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            busy      <= (state_nxt_s == S_LOAD);
            done      <= (state_nxt_s == S_DONE);
            error     <= (state_nxt_s == S_ERR);
            core_hold <= (state_nxt_s != S_DONE);
        end
    end

    // Load parameters, running address, word count and checksum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r       <= {ADDR_W{1'b0}};
            num_r        <= {CNT_W{1'b0}};
            words_loaded <= {CNT_W{1'b0}};
            checksum     <= {DATA_W{1'b0}};
        end else if (launch_s) begin
            addr_r       <= base_addr & ALIGN_MASK;
            num_r        <= num_words;
            words_loaded <= {CNT_W{1'b0}};
            checksum     <= {DATA_W{1'b0}};
        end else if (xfer_s && in_range_s) begin
            addr_r       <= addr_r + STEP;
            words_loaded <= words_loaded + CNT_W'(1);
            checksum     <= checksum + bus.in_data;
        end
    end

    // Registered memory write port; address and data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
        end else if (xfer_s && in_range_s) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_r;
            bus.mem_wdata <= bus.in_data;
        end else begin
            bus.mem_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Two loaders (byte-addressed DEPTH=4, word-addressed DEPTH=16) share one stimulus stream;
// a reference model fills a scoreboard that a separate monitor drains on every mem_we.
module tb_prog_mem_loader;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int CW      = 16;
    localparam int DEPTH_B = 4;
    localparam int DEPTH_W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = 32'h0;
    logic [CW-1:0] num_words = 16'h0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = 32'h0;

    prog_mem_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
    prog_mem_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus_w ();

    logic [1:0]    hold_v, busy_v, done_v, err_v, we_v, rdy_v;
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] wdata_v [2];
    logic [DW-1:0] csum_v  [2];
    logic [CW-1:0] wl_v    [2];

    assign bus_b.in_valid = in_valid;
    assign bus_b.in_data  = in_data;
    assign bus_w.in_valid = in_valid;
    assign bus_w.in_data  = in_data;
    assign we_v       = {bus_w.mem_we, bus_b.mem_we};
    assign rdy_v      = {bus_w.in_ready, bus_b.in_ready};
    assign addr_v[0]  = bus_b.mem_addr;
    assign addr_v[1]  = bus_w.mem_addr;
    assign wdata_v[0] = bus_b.mem_wdata;
    assign wdata_v[1] = bus_w.mem_wdata;

    always #5 clk = ~clk;

    prog_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_B), .CNT_W(CW), .BYTE_ADDR(1)) u_byte (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .bus(bus_b), .core_hold(hold_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .error(err_v[0]), .checksum(csum_v[0]), .words_loaded(wl_v[0])
    );

    prog_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_W), .CNT_W(CW), .BYTE_ADDR(0)) u_word (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .bus(bus_w), .core_hold(hold_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .error(err_v[1]), .checksum(csum_v[1]), .words_loaded(wl_v[1])
    );

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] wq[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h want=%0h", nm, d, act, exp);
        end
    endtask

    // Address of the k-th word: byte mode steps 4 from a word-aligned base, word mode steps 1
    function automatic logic [31:0] exp_addr(input int d, input logic [31:0] base, input int k);
        if (d == 0) return (base / 32'd4) * 32'd4 + 32'(k) * 32'd4;
        else        return base + 32'(k);
    endfunction

    function automatic int first_bad(input int d, input logic [31:0] base, input int num);
        logic [31:0] a;
        logic [31:0] idx;
        for (int k = 0; k < num; k++) begin
            a   = exp_addr(d, base, k);
            idx = (d == 0) ? a / 32'd4 : a;
            if (idx >= 32'((d == 0) ? DEPTH_B : DEPTH_W)) return k;
        end
        return -1;
    endfunction

    task automatic fill_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    task automatic chk_reset_state();
        for (int d = 0; d < 2; d++) begin
            chk("rst_hold",  d, 64'(hold_v[d]), 64'd1);
            chk("rst_ready", d, 64'(rdy_v[d]),  64'd0);
            chk("rst_we",    d, 64'(we_v[d]),   64'd0);
            chk("rst_addr",  d, 64'(addr_v[d]), 64'd0);
            chk("rst_wdata", d, 64'(wdata_v[d]), 64'd0);
            chk("rst_busy",  d, 64'(busy_v[d]), 64'd0);
            chk("rst_done",  d, 64'(done_v[d]), 64'd0);
            chk("rst_err",   d, 64'(err_v[d]),  64'd0);
            chk("rst_csum",  d, 64'(csum_v[d]), 64'd0);
            chk("rst_wl",    d, 64'(wl_v[d]),   64'd0);
        end
    endtask

    // gap < 0 picks a random 0..2 idle cycles before each word
    task automatic run_load(input logic [31:0] base, input int num, input int gap);
        int          bad[2];
        int          acc[2];
        int          good[2];
        int          need;
        int          g;
        int          pend;
        logic [31:0] sum;
        need = 0;
        for (int d = 0; d < 2; d++) begin
            bad[d]  = first_bad(d, base, num);
            good[d] = (bad[d] < 0) ? num : bad[d];
            acc[d]  = (bad[d] < 0) ? num : bad[d] + 1;
            if (acc[d] > need) need = acc[d];
            for (int k = 0; k < good[d]; k++)
                sbq.push_back('{d, exp_addr(d, base, k), wq[k], (bad[d] < 0) && (k == num - 1)});
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; num_words = CW'(num);
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("start_busy", d, 64'(busy_v[d]), 64'(num > 0));
            chk("start_done", d, 64'(done_v[d]), 64'(num == 0));
            chk("start_hold", d, 64'(hold_v[d]), 64'(num > 0));
        end
        // two surplus words must be ignored once each loader has left LOAD
        for (int v = 0; v < need + 2; v++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int i = 0; i < g; i++) begin
                for (int d = 0; d < 2; d++) begin
                    if (v < acc[d]) begin
                        chk("gap_ready", d, 64'(rdy_v[d]),  64'd1);
                        chk("gap_busy",  d, 64'(busy_v[d]), 64'd1);
                    end
                end
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = wq[v];
            @(negedge clk);
            in_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sum = 32'h0;
            for (int k = 0; k < good[d]; k++) sum = sum + wq[k];
            pend = 0;
            foreach (sbq[i]) if (sbq[i].d == d) pend++;
            chk("end_done",  d, 64'(done_v[d]), 64'(bad[d] < 0));
            chk("end_err",   d, 64'(err_v[d]),  64'(bad[d] >= 0));
            chk("end_hold",  d, 64'(hold_v[d]), 64'(bad[d] >= 0));
            chk("end_busy",  d, 64'(busy_v[d]), 64'd0);
            chk("end_ready", d, 64'(rdy_v[d]),  64'd0);
            chk("end_wl",    d, 64'(wl_v[d]),   64'(good[d]));
            chk("end_csum",  d, 64'(csum_v[d]), 64'(sum));
            chk("sb_drained", d, 64'(pend),     64'd0);
        end
    endtask

    // Monitor: every mem_we must match the oldest outstanding write for that loader
    initial begin
        logic [AW-1:0] pa[2];
        logic [DW-1:0] pd[2];
        logic          pe[2];
        int            idx;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    pa[d] = 32'h0; pd[d] = 32'h0; pe[d] = 1'b0;
                end else begin
                    if (we_v[d]) begin
                        idx = -1;
                        for (int i = 0; i < sbq.size(); i++)
                            if (idx < 0 && sbq[i].d == d) idx = i;
                        if (idx < 0) begin
                            checks++;
                            errors++;
                            $display("FAIL extra_write dut%0d got addr=%0h want no write", d, addr_v[d]);
                        end else begin
                            chk("wr_addr",   d, 64'(addr_v[d]),  64'(sbq[idx].addr));
                            chk("wr_data",   d, 64'(wdata_v[d]), 64'(sbq[idx].data));
                            chk("wr_done",   d, 64'(done_v[d]),  64'(sbq[idx].last));
                            chk("wr_hold",   d, 64'(hold_v[d]),  64'(!sbq[idx].last));
                            sbq.delete(idx);
                        end
                    end else begin
                        chk("hold_addr",  d, 64'(addr_v[d]),  64'(pa[d]));
                        chk("hold_wdata", d, 64'(wdata_v[d]), 64'(pd[d]));
                    end
                    if (err_v[d] && !pe[d]) chk("err_no_we", d, 64'(we_v[d]), 64'd0);
                    pa[d] = addr_v[d]; pd[d] = wdata_v[d]; pe[d] = err_v[d];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog dut0 got=timeout want=finish");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_state();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("idle_busy", d, 64'(busy_v[d]), 64'd0);
            chk("idle_done", d, 64'(done_v[d]), 64'd0);
            chk("idle_hold", d, 64'(hold_v[d]), 64'd1);
        end

        wq = '{32'h00500193, 32'h00200213, 32'h004182B3, 32'h0000_0013, 32'h0000_0013};
        run_load(32'h0, 3, 0);
        run_load(32'h0, 3, 2);
        fill_words(5);
        run_load(32'h8, 3, 0);
        fill_words(3);
        run_load(32'h0, 1, 0);
        run_load(32'h10, 0, 0);
        fill_words(4);
        run_load(32'h5, 2, 1);
        fill_words(4);
        run_load(32'h6, 2, 0);

        // reset after the first of three words
        fill_words(3);
        sbq.push_back('{0, 32'h0, wq[0], 1'b0});
        sbq.push_back('{1, 32'h0, wq[0], 1'b0});
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0; num_words = 16'd3;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = wq[0];
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_state();
        sbq.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        fill_words(5);
        run_load(32'h0, 3, 0);

        repeat (40) begin
            fill_words(9);
            run_load(32'($urandom_range(0, 24)), int'($urandom_range(0, 6)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
